// File: rtl/fnorm_shift_pipe_pkg.sv
// Shared constants and types for the FPU adder normalizer.
//   MW       : mantissa width including the carry bit (bit MW-1)
//   EW       : exponent width
//   SW       : width of the leading-zero code from the adder priority encoder
//   SE_ZERO  : leading-zero code meaning "mantissa bits 25:0 are all zero"
//   EXP_MAX  : saturated exponent used to flag overflow
//   s1_payload_t : state carried from stage 1 into stage 2
package fnorm_shift_pipe_pkg;

  localparam int unsigned MW = 27;
  localparam int unsigned EW = 8;
  localparam int unsigned SW = 5;

  localparam logic [SW-1:0] SE_ZERO = 5'd26;
  localparam logic [EW-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic [MW-1:0] m1;   // mantissa after carry fix-up or coarse shift
    logic [EW-1:0] exp;  // pre-normalization exponent
    logic [SW-1:0] se;   // full shift amount; forced to 0 on the carry path
    logic          c;    // carry out into bit MW-1
    logic          z;    // input is zero (or an illegal shift code)
  } s1_payload_t;

  // Zero-extend a shift code to exponent width for exponent arithmetic.
  function automatic logic [EW-1:0] se_to_exp(input logic [SW-1:0] se);
    return {{(EW - SW){1'b0}}, se};
  endfunction

endpackage

// File: rtl/fnorm_lshift_fine.sv
// Combinational fine left shifter, 0..7 bit positions, zero fill.
//   data_i  : operand
//   shamt_i : shift amount (0..7)
//   data_o  : data_i << shamt_i, truncated to Width bits
module fnorm_lshift_fine #(
  parameter int unsigned Width = 27
) (
  input  logic [Width-1:0] data_i,
  input  logic [2:0]       shamt_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] stage;

  // Three-level log shifter: 1, 2 and 4 positions.
  always_comb begin
    stage = data_i;
    if (shamt_i[0]) stage = {stage[Width-2:0], 1'b0};
    if (shamt_i[1]) stage = {stage[Width-3:0], 2'b0};
    if (shamt_i[2]) stage = {stage[Width-5:0], 4'b0};
    data_o = stage;
  end

endmodule

// File: rtl/fnorm_shift_pipe.sv
// Two-stage pipelined normalizer for the FPU adder datapath.
//
// Stage 1 folds a carry into bit MW-1 as a sticky 1-bit right shift, or otherwise performs
// the coarse (multiple-of-8) part of the left shift selected by the leading-zero code.
// Stage 2 performs the fine 0..7 left shift and the exponent adjustment, flagging zero,
// underflow flush and overflow. Valid/ready on both sides with full backpressure.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat this cycle
//   in_myd     : unnormalized mantissa (bit 26 = carry)
//   in_se      : leading-zero code (0..26; 27..31 treated as zero input)
//   in_exp     : pre-normalization exponent
//   out_valid  : result valid
//   out_ready  : consumer accepts result
//   out_man    : normalized mantissa, leading one at bit 25
//   out_exp    : adjusted exponent
//   out_zero   : result is zero (zero input or underflow flush)
//   out_ovf    : exponent overflow (out_exp = 8'hFF, out_man = 0)
module fnorm_shift_pipe
  import fnorm_shift_pipe_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_myd,
  input  logic [SW-1:0] in_se,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_man,
  output logic [EW-1:0] out_exp,
  output logic          out_zero,
  output logic          out_ovf
);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic        s1_valid_q, s1_valid_d;
  logic        out_valid_q, out_valid_d;
  logic        s2_adv;     // output register may take a new value this cycle
  logic        s1_accept;  // input beat transfers this cycle

  assign s2_adv    = !out_valid_q || out_ready;
  // Stage 1 drains into stage 2 whenever stage 2 advances.
  assign in_ready  = !s1_valid_q || s2_adv;
  assign s1_accept = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

  // ---------------------------------------------------------------------------
  // Stage 1: carry fix-up or coarse shift
  // ---------------------------------------------------------------------------
  s1_payload_t   s1_d, s1_q;
  logic [MW-1:0] coarse_man;

  always_comb begin
    coarse_man = in_myd << {in_se[4:3], 3'b000};

    s1_d     = '0;
    s1_d.exp = in_exp;
    s1_d.c   = in_myd[MW-1];
    if (s1_d.c) begin
      // Right shift by one, folding the dropped bit into a sticky LSB.
      s1_d.m1 = {1'b0, in_myd[MW-1:2], in_myd[1] | in_myd[0]};
      s1_d.se = '0;
    end else begin
      s1_d.m1 = coarse_man;
      s1_d.se = in_se;
    end
    // Codes 27..31 fall in here too and are handled as a zero input.
    s1_d.z = !s1_d.c && (in_se >= SE_ZERO);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: fine shift and exponent adjustment
  // ---------------------------------------------------------------------------
  logic [MW-1:0] fine_man;
  logic [EW:0]   exp_inc;
  logic [EW-1:0] se_ext;
  logic [MW-1:0] out_man_d, out_man_q;
  logic [EW-1:0] out_exp_d, out_exp_q;
  logic          out_zero_d, out_zero_q;
  logic          out_ovf_d, out_ovf_q;

  fnorm_lshift_fine #(
    .Width (MW)
  ) u_lshift_fine (
    .data_i  (s1_q.m1),
    .shamt_i (s1_q.se[2:0]),
    .data_o  (fine_man)
  );

  assign exp_inc = {1'b0, s1_q.exp} + {{EW{1'b0}}, 1'b1};
  assign se_ext  = se_to_exp(s1_q.se);

  always_comb begin
    out_man_d  = '0;
    out_exp_d  = '0;
    out_zero_d = 1'b0;
    out_ovf_d  = 1'b0;
    if (s1_q.c) begin
      // Carry path: shift amount was forced to 0, so fine_man == m1.
      if (exp_inc >= {1'b0, EXP_MAX}) begin
        out_ovf_d = 1'b1;
        out_exp_d = EXP_MAX;
      end else begin
        out_man_d = fine_man;
        out_exp_d = exp_inc[EW-1:0];
      end
    end else if (s1_q.z) begin
      out_zero_d = 1'b1;
    end else if (s1_q.exp <= se_ext) begin
      // Normalizing would drive the exponent to zero or below: flush.
      out_zero_d = 1'b1;
    end else begin
      out_man_d = fine_man;
      out_exp_d = s1_q.exp - se_ext;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_man_q   <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s1_accept) begin
        s1_q <= s1_d;
      end
      // Payload only moves with a real beat so outputs hold while stalled.
      if (s2_adv && s1_valid_q) begin
        out_man_q  <= out_man_d;
        out_exp_q  <= out_exp_d;
        out_zero_q <= out_zero_d;
        out_ovf_q  <= out_ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_man   = out_man_q;
  assign out_exp   = out_exp_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_fnorm_shift_pipe.sv
// Self-checking bench for fnorm_shift_pipe: scoreboard of expected results computed
// arithmetically from the input beat, directed vectors with literal expectations,
// backpressure, mid-flight reset and a randomized stream with random out_ready.
module tb_fnorm_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] in_myd;
  logic [4:0]  in_se;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_man;
  logic [7:0]  out_exp;
  logic        out_zero;
  logic        out_ovf;

  fnorm_shift_pipe u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_myd    (in_myd),
    .in_se     (in_se),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_man   (out_man),
    .out_exp   (out_exp),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] man;
    logic [7:0]  exp;
    logic        zero;
    logic        ovf;
    bit          has_lit;
    logic [26:0] lman;
    logic [7:0]  lexp;
    logic        lzero;
    logic        lovf;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Literal expectation attached to the beat currently being driven.
  bit          lit_has;
  logic [26:0] lit_man;
  logic [7:0]  lit_exp;
  logic        lit_zero;
  logic        lit_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Normalization computed directly from the arithmetic meaning of the inputs.
  function automatic res_t model(input logic [26:0] myd, input logic [4:0] se,
                                 input logic [7:0] ex);
    res_t        r;
    int unsigned e;
    r = '{default: '0};
    if (myd[26]) begin
      e = int'(ex) + 1;
      if (e >= 255) begin
        r.ovf = 1'b1;
        r.exp = 8'hFF;
      end else begin
        r.man = (myd >> 1) | {26'd0, myd[0]};
        r.exp = 8'(e);
      end
    end else if (int'(se) >= 26 || int'(ex) <= int'(se)) begin
      r.zero = 1'b1;
    end else begin
      r.man = myd << se;
      r.exp = ex - {3'b000, se};
    end
    return r;
  endfunction

  // Monitor / compare process, sampled on the falling edge.
  bit          stalled = 1'b0;
  logic [26:0] held_man;
  logic [7:0]  held_exp;
  logic        held_zero;
  logic        held_ovf;

  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_man", 32'(out_man), 32'(held_man));
        chk("stall_exp", 32'(out_exp), 32'(held_exp));
        chk("stall_flags", {30'd0, out_zero, out_ovf}, {30'd0, held_zero, held_ovf});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=man %0h exp %0h required=no result pending",
                   out_man, out_exp);
        end else begin
          e = sb.pop_front();
          chk("man", 32'(out_man), 32'(e.man));
          chk("exp", 32'(out_exp), 32'(e.exp));
          chk("zero", 32'(out_zero), 32'(e.zero));
          chk("ovf", 32'(out_ovf), 32'(e.ovf));
          if (e.has_lit) begin
            chk("lit_man", 32'(out_man), 32'(e.lman));
            chk("lit_exp", 32'(out_exp), 32'(e.lexp));
            chk("lit_zero", 32'(out_zero), 32'(e.lzero));
            chk("lit_ovf", 32'(out_ovf), 32'(e.lovf));
          end
        end
      end
      stalled   = out_valid && !out_ready;
      held_man  = out_man;
      held_exp  = out_exp;
      held_zero = out_zero;
      held_ovf  = out_ovf;
      if (in_valid && in_ready) begin
        e         = model(in_myd, in_se, in_exp);
        e.has_lit = lit_has;
        e.lman    = lit_man;
        e.lexp    = lit_exp;
        e.lzero   = lit_zero;
        e.lovf    = lit_ovf;
        sb.push_back(e);
      end
    end
  end

  // Drive one beat (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic send(input logic [26:0] m, input logic [4:0] s, input logic [7:0] ex,
                      input bit hl, input logic [26:0] lm, input logic [7:0] le,
                      input logic lz, input logic lo);
    int n;
    bit acc;
    in_myd   = m;
    in_se    = s;
    in_exp   = ex;
    lit_has  = hl;
    lit_man  = lm;
    lit_exp  = le;
    lit_zero = lz;
    lit_ovf  = lo;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready low for %0d cycles required=accept", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_has  = 1'b0;
  endtask

  task automatic send_rand();
    logic [26:0] rnd;
    logic [26:0] lead;
    logic [4:0]  s;
    logic [7:0]  ex;
    int          r;
    rnd = 27'($urandom());
    r   = int'($urandom_range(0, 9));
    ex  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom());
    if (r == 0) begin
      rnd[26] = 1'b1;
      s       = 5'($urandom());
      if ($urandom_range(0, 1) == 1) ex = 8'($urandom_range(250, 255));
    end else if (r == 1) begin
      rnd[26] = 1'b0;
      s       = 5'($urandom_range(26, 31));
    end else begin
      s    = 5'($urandom_range(0, 25));
      lead = 27'h2000000 >> s;
      rnd  = lead | (rnd & (lead - 27'd1));
    end
    send(rnd, s, ex, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=still running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1, "watchdog");
  end

  bit rand_done;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_myd    = '0;
    in_se     = '0;
    in_exp    = '0;
    out_ready = 1'b1;
    lit_has   = 1'b0;
    lit_man   = '0;
    lit_exp   = '0;
    lit_zero  = 1'b0;
    lit_ovf   = 1'b0;
    rand_done = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_man", 32'(out_man), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    chk("rst_flags", {30'd0, out_zero, out_ovf}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with hand-computed results, streamed back to back.
    send(27'h2000000, 5'd0, 8'd100, 1'b1, 27'h2000000, 8'd100, 1'b0, 1'b0);
    send(27'h0000001, 5'd25, 8'd130, 1'b1, 27'h2000000, 8'd105, 1'b0, 1'b0);
    send(27'h4000003, 5'd0, 8'd254, 1'b1, 27'h0000000, 8'hFF, 1'b0, 1'b1);
    send(27'h4000003, 5'd0, 8'd10, 1'b1, 27'h2000001, 8'd11, 1'b0, 1'b0);
    send(27'h0000000, 5'd26, 8'd50, 1'b1, 27'h0000000, 8'd0, 1'b1, 1'b0);
    send(27'h0000100, 5'd17, 8'd17, 1'b1, 27'h0000000, 8'd0, 1'b1, 1'b0);
    send(27'h0000123, 5'd30, 8'd77, 1'b1, 27'h0000000, 8'd0, 1'b1, 1'b0);
    send(27'h0123456, 5'd1, 8'd200, 1'b1, 27'h02468AC, 8'd199, 1'b0, 1'b0);
    drain();

    // Backpressure: four beats against a consumer stalled for five cycles.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(27'h0400000, 5'd3, 8'd90, 1'b0, '0, '0, 1'b0, 1'b0);
    send(27'h0000FFF, 5'd14, 8'd60, 1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_man", 32'(out_man), 32'd0);
    chk("midrst_out_exp", 32'(out_exp), 32'd0);
    chk("midrst_flags", {30'd0, out_zero, out_ovf}, 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_myd   = 27'h0000001;
    in_se    = 5'd25;
    in_exp   = 8'd130;
    lit_has  = 1'b1;
    lit_man  = 27'h2000000;
    lit_exp  = 8'd105;
    lit_zero = 1'b0;
    lit_ovf  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lit_has  = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drain();

    // Randomized stream with random idle gaps and random consumer stalls.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          repeat ($urandom_range(0, 3) == 0 ? 1 : 0) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("end_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
